// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: a CPU write to DMA_REG halts the CPU and copies 256 bytes
// from page {page,8'h00} to OAM_PORT as READ/WRITE pairs, with an optional alignment cycle.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG  = 16'h4014,
    parameter logic [15:0] OAM_PORT = 16'h2004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_d_out,
    input  logic        cpu_write,
    input  logic [7:0]  mem_d_in,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_d_out,
    output logic        mem_write,
    output logic        cpu_hold,
    output logic        busy,
    output logic        dma_done
);

    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

    state_t     state_reg, state_next;
    logic [7:0] page_reg, page_next;
    logic [7:0] idx_reg, idx_next;
    logic [7:0] latch_reg, latch_next;
    logic       parity_reg;
    logic       dma_done_reg, dma_done_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            page_reg     <= 8'h00;
            idx_reg      <= 8'h00;
            latch_reg    <= 8'h00;
            parity_reg   <= 1'b0;
            dma_done_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            page_reg     <= page_next;
            idx_reg      <= idx_next;
            latch_reg    <= latch_next;
            parity_reg   <= ~parity_reg;
            dma_done_reg <= dma_done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        page_next     = page_reg;
        idx_next      = idx_reg;
        latch_next    = latch_reg;
        dma_done_next = 1'b0;
        // Idle bus is a zero-latency pass-through of the CPU, including the trigger write itself
        mem_addr      = cpu_addr;
        mem_d_out     = cpu_d_out;
        mem_write     = cpu_write;
        case (state_reg)
            IDLE: begin
                if (cpu_write && (cpu_addr == DMA_REG)) begin
                    page_next  = cpu_d_out;
                    idx_next   = 8'h00;
                    state_next = HALT;
                end
            end
            HALT: begin
                mem_addr   = {page_reg, 8'h00};
                mem_d_out  = 8'h00;
                mem_write  = 1'b0;
                // Odd parity means the read would land on the wrong phase; burn one cycle
                state_next = parity_reg ? ALIGN : READ;
            end
            ALIGN: begin
                mem_addr   = {page_reg, 8'h00};
                mem_d_out  = 8'h00;
                mem_write  = 1'b0;
                state_next = READ;
            end
            READ: begin
                mem_addr   = {page_reg, idx_reg};
                mem_d_out  = 8'h00;
                mem_write  = 1'b0;
                latch_next = mem_d_in;
                state_next = WRITE;
            end
            WRITE: begin
                mem_addr   = OAM_PORT;
                mem_d_out  = latch_reg;
                mem_write  = 1'b1;
                idx_next   = idx_reg + 8'd1;
                if (idx_reg == 8'hFF) begin
                    state_next    = IDLE;
                    dma_done_next = 1'b1;
                end else begin
                    state_next = READ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign cpu_hold = (state_reg != IDLE);
    assign busy     = (state_reg != IDLE);
    assign dma_done = dma_done_reg;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: memory returns addr[7:0]^key, each scenario
// checks hold length, read order, OAM write data and the done pulse.
module tb_oam_dma_ctrl;

    localparam logic [15:0] DMA = 16'h4014;
    localparam logic [15:0] OAM = 16'h2004;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_d_out;
    logic        cpu_write;
    logic [7:0]  mem_d_in;
    logic [15:0] mem_addr;
    logic [7:0]  mem_d_out;
    logic        mem_write;
    logic        cpu_hold;
    logic        busy;
    logic        dma_done;

    logic [7:0]  key;
    logic [31:0] cnt;
    int          checks;
    int          errors;

    // results of the last observed transfer
    int          o_hold, o_wr, o_bad_rd, o_bad_wr, o_done, o_done_bad, o_busy_bad;
    logic [15:0] o_last_rd;
    logic [7:0]  o_first;
    bit          o_timeout, o_aborted;
    logic        ab_hold, ab_busy, ab_mw, ab_pt_w;
    logic [15:0] ab_pt_addr;
    logic [7:0]  ab_pt_d;
    logic [15:0] t_addr;
    logic [7:0]  t_data;
    logic        t_wr;

    oam_dma_ctrl #(.DMA_REG(16'h4014), .OAM_PORT(16'h2004)) dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_d_out(cpu_d_out),
        .cpu_write(cpu_write), .mem_d_in(mem_d_in), .mem_addr(mem_addr),
        .mem_d_out(mem_d_out), .mem_write(mem_write), .cpu_hold(cpu_hold),
        .busy(busy), .dma_done(dma_done)
    );

    assign mem_d_in = mem_addr[7:0] ^ key;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // edges since reset release; its LSB is the controller's parity
    always @(posedge clk or negedge rst) begin
        if (!rst) cnt <= 32'd0;
        else      cnt <= cnt + 32'd1;
    end

    task automatic trigger(input logic [7:0] pg, input bit halt_par);
        @(posedge clk); #1;
        if (cnt[0] == halt_par) begin @(posedge clk); #1; end
        cpu_addr = DMA; cpu_d_out = pg; cpu_write = 1'b1;
        #1;
        t_addr = mem_addr; t_data = mem_d_out; t_wr = mem_write;
        @(posedge clk); #1;
        cpu_write = 1'b0; cpu_addr = 16'h0000; cpu_d_out = 8'h00;
        #1;
    endtask

    task automatic observe(input logic [7:0] pg, input bit inject, input bit abort);
        logic [15:0] prev_addr;
        bit seen, injected;
        int idle_after;
        o_hold = 0; o_wr = 0; o_bad_rd = 0; o_bad_wr = 0; o_done = 0;
        o_done_bad = 0; o_busy_bad = 0; o_last_rd = 16'h0000; o_first = 8'h00;
        o_timeout = 1'b1; o_aborted = 1'b0;
        seen = 1'b0; injected = 1'b0; idle_after = 0;
        prev_addr = mem_addr;
        for (int cyc = 0; cyc < 700; cyc++) begin
            if (busy !== cpu_hold) o_busy_bad++;
            if (dma_done === 1'b1) begin
                o_done++;
                if (cpu_hold !== 1'b0) o_done_bad++;
            end
            if (cpu_hold === 1'b1) begin
                seen = 1'b1;
                o_hold++;
                if (mem_write === 1'b1) begin
                    if (prev_addr !== {pg, o_wr[7:0]}) o_bad_rd++;
                    if (mem_addr !== OAM || mem_d_out !== (o_wr[7:0] ^ key)) o_bad_wr++;
                    if (o_wr == 0) o_first = mem_d_out;
                    o_last_rd = prev_addr;
                    if (abort && o_wr == 128) begin
                        rst = 1'b0;
                        #1;
                        ab_hold = cpu_hold; ab_busy = busy; ab_mw = mem_write;
                        cpu_addr = 16'h0300; cpu_d_out = 8'h11; cpu_write = 1'b1;
                        #1;
                        ab_pt_addr = mem_addr; ab_pt_d = mem_d_out; ab_pt_w = mem_write;
                        cpu_write = 1'b0; cpu_addr = 16'h0000; cpu_d_out = 8'h00;
                        o_aborted = 1'b1; o_timeout = 1'b0;
                        break;
                    end
                    o_wr++;
                end
            end else if (seen) begin
                idle_after++;
                if (idle_after == 3) begin o_timeout = 1'b0; break; end
            end
            if (inject && !injected && o_wr == 64) begin
                cpu_addr = DMA; cpu_d_out = 8'h77; cpu_write = 1'b1;
                injected = 1'b1;
            end
            prev_addr = mem_addr;
            @(posedge clk); #1;
            cpu_write = 1'b0; cpu_addr = 16'h0000; cpu_d_out = 8'h00;
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; cpu_addr = 16'h1234; cpu_d_out = 8'h56; cpu_write = 1'b1; key = 8'h3C;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (cpu_hold !== 1'b0 || busy !== 1'b0 || dma_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: hold=%b busy=%b done=%b expected 0 0 0", cpu_hold, busy, dma_done);
        end
        checks++;
        if (mem_addr !== 16'h1234 || mem_d_out !== 8'h56 || mem_write !== 1'b1) begin
            errors++;
            $display("FAIL reset_passthru: addr=%h d=%h w=%b expected 1234 56 1", mem_addr, mem_d_out, mem_write);
        end
        cpu_write = 1'b0; cpu_addr = 16'h0000; cpu_d_out = 8'h00;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (busy !== 1'b0 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: busy=%b hold=%b expected 0 0", busy, cpu_hold);
        end
    endtask

    task automatic check_transfer(input string tag, input int exp_hold, input logic [15:0] exp_last);
        checks++;
        if (o_timeout !== 1'b0) begin errors++; $display("FAIL %s_timeout: transfer did not finish", tag); end
        checks++;
        if (o_hold != exp_hold) begin errors++; $display("FAIL %s_hold: got %0d expected %0d", tag, o_hold, exp_hold); end
        checks++;
        if (o_wr != 256) begin errors++; $display("FAIL %s_writes: got %0d expected 256", tag, o_wr); end
        checks++;
        if (o_bad_rd != 0) begin errors++; $display("FAIL %s_read_order: got %0d bad reads expected 0", tag, o_bad_rd); end
        checks++;
        if (o_bad_wr != 0) begin errors++; $display("FAIL %s_oam_data: got %0d bad writes expected 0", tag, o_bad_wr); end
        checks++;
        if (o_done != 1 || o_done_bad != 0) begin
            errors++;
            $display("FAIL %s_done: got %0d pulses (%0d while held) expected 1 (0)", tag, o_done, o_done_bad);
        end
        checks++;
        if (o_last_rd !== exp_last) begin errors++; $display("FAIL %s_last_read: got %h expected %h", tag, o_last_rd, exp_last); end
        checks++;
        if (o_busy_bad != 0) begin errors++; $display("FAIL %s_busy: got %0d busy/hold mismatches expected 0", tag, o_busy_bad); end
    endtask

    task automatic test_even_parity;
        key = 8'h3C;
        trigger(8'h02, 1'b0);
        checks++;
        if (t_addr !== DMA || t_data !== 8'h02 || t_wr !== 1'b1) begin
            errors++;
            $display("FAIL trigger_passthru: addr=%h d=%h w=%b expected 4014 02 1", t_addr, t_data, t_wr);
        end
        observe(8'h02, 1'b0, 1'b0);
        check_transfer("even", 513, 16'h02FF);
    endtask

    task automatic test_odd_parity;
        key = 8'h3C;
        trigger(8'h02, 1'b1);
        observe(8'h02, 1'b0, 1'b0);
        check_transfer("odd", 514, 16'h02FF);
    endtask

    task automatic test_page_ff;
        key = 8'hA5;
        trigger(8'hFF, 1'b0);
        observe(8'hFF, 1'b0, 1'b0);
        check_transfer("page_ff", 513, 16'hFFFF);
        checks++;
        if (o_first !== 8'hA5) begin errors++; $display("FAIL page_ff_first: got %h expected a5", o_first); end
    endtask

    task automatic test_retrigger_ignored;
        key = 8'h3C;
        trigger(8'h05, 1'b0);
        observe(8'h05, 1'b1, 1'b0);
        check_transfer("retrig", 513, 16'h05FF);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL retrig_restart: busy=%b expected 0", busy); end
    endtask

    task automatic test_reset_abort;
        key = 8'h3C;
        trigger(8'h03, 1'b0);
        observe(8'h03, 1'b0, 1'b1);
        checks++;
        if (o_aborted !== 1'b1) begin errors++; $display("FAIL abort_reached: got %b expected 1", o_aborted); end
        checks++;
        if (ab_hold !== 1'b0 || ab_busy !== 1'b0 || ab_mw !== 1'b0) begin
            errors++;
            $display("FAIL abort_status: hold=%b busy=%b w=%b expected 0 0 0", ab_hold, ab_busy, ab_mw);
        end
        checks++;
        if (ab_pt_addr !== 16'h0300 || ab_pt_d !== 8'h11 || ab_pt_w !== 1'b1) begin
            errors++;
            $display("FAIL abort_passthru: addr=%h d=%h w=%b expected 0300 11 1", ab_pt_addr, ab_pt_d, ab_pt_w);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        trigger(8'h03, 1'b1);
        observe(8'h03, 1'b0, 1'b0);
        check_transfer("restart", 514, 16'h03FF);
        checks++;
        if (o_first !== 8'h3C) begin errors++; $display("FAIL restart_first: got %h expected 3c", o_first); end
    endtask

    task automatic test_no_trigger;
        bit saw_busy;
        saw_busy = 1'b0;
        @(posedge clk); #1;
        cpu_addr = 16'h4015; cpu_d_out = 8'h09; cpu_write = 1'b1;
        #1;
        checks++;
        if (mem_addr !== 16'h4015 || mem_d_out !== 8'h09 || mem_write !== 1'b1) begin
            errors++;
            $display("FAIL other_reg_passthru: addr=%h d=%h w=%b expected 4015 09 1", mem_addr, mem_d_out, mem_write);
        end
        @(posedge clk); #1;
        cpu_addr = DMA; cpu_d_out = 8'h02; cpu_write = 1'b0;
        #1;
        checks++;
        if (mem_addr !== DMA || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL read_passthru: addr=%h w=%b expected 4014 0", mem_addr, mem_write);
        end
        for (int i = 0; i < 4; i++) begin
            if (busy !== 1'b0 || cpu_hold !== 1'b0) saw_busy = 1'b1;
            @(posedge clk); #2;
        end
        checks++;
        if (saw_busy) begin errors++; $display("FAIL no_trigger_busy: got 1 expected 0"); end
        cpu_addr = 16'h0000; cpu_d_out = 8'h00;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b0; cpu_addr = 16'h0000; cpu_d_out = 8'h00; cpu_write = 1'b0; key = 8'h00;
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_page_ff();
        test_retrigger_ignored();
        test_reset_abort();
        test_no_trigger();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
